fetch_stage: RTL

- PC register and instruction-fetch controller for the multi-cycle core; sits directly downstream of the next-PC logic and upstream of decode.
- Holds the architectural PC and issues one instruction-memory request at a time.
- Presents the fetched instruction to decode with a valid/ready handshake.
- On retire (decode accepts the instruction), loads the combinational next-PC value into the PC and starts the next fetch.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 34 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: instruction width, default NOP encoding and FSM encodings.
package fetch_stage_pkg;

  localparam int unsigned INSTR_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_TRAP = 3'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register with synchronous reset, load enable and optional word-alignment masking.
module fetch_pc_reg #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0,
  parameter bit                     ALIGN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic [DATA_WIDTH-1:0] pc_out
);

  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = pc_in;
    if (ALIGN) begin
      pc_d = {pc_in[DATA_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch controller: one outstanding imem request, valid/ready hand-off to decode.
// Define MISALIGN_TRAP_EN to trap on a misaligned retire target instead of masking it.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   pc_next,
  output logic [DATA_WIDTH-1:0]   pc_current,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic                    imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]  imem_rsp_data,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_WIDTH-1:0]  instr,
  output logic [DATA_WIDTH-1:0]   instr_pc,
  output logic [31:0]             retired_count,
  output logic                    misalign_trap
);

  logic [2:0]             state_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0]  instr_pc_q;
  logic [31:0]            count_q;
  logic                   retire;
  logic                   pc_load;

  assign retire = (state_q == ST_HOLD) && instr_ready;

`ifdef MISALIGN_TRAP_EN
  localparam bit PcAlign = 1'b0;
  logic misaligned;
  logic trap_q;

  assign misaligned = (pc_next[1:0] != 2'b00);
  // A trapping retire leaves the PC on the retiring instruction.
  assign pc_load    = retire && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (retire && misaligned) begin
      trap_q <= 1'b1;
    end
  end

  assign misalign_trap = trap_q;
`else
  localparam bit PcAlign = 1'b1;
  assign pc_load       = retire;
  assign misalign_trap = 1'b0;
`endif

  fetch_pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC),
    .ALIGN      (PcAlign)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load_en (pc_load),
    .pc_in   (pc_next),
    .pc_out  (pc_current)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      count_q    <= 32'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q    <= imem_rsp_data;
            instr_pc_q <= pc_current;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            count_q <= count_q + 32'd1;
            instr_q <= NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
            state_q <= misaligned ? ST_TRAP : ST_REQ;
`else
            state_q <= ST_REQ;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        ST_TRAP: state_q <= ST_TRAP;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_addr      = pc_current;
  assign instr_valid    = (state_q == ST_HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign retired_count  = count_q;

endmodule
